// File: rtl/cndm_proto_dma_rd_sched.sv
// cndm_proto_dma_rd_sched
// Credit-limited round-robin scheduler that shares one DMA read descriptor
// channel between PORTS clients. The client index is stamped into the upper
// m_req_tag bits, and read statuses are routed back to the originating client.
// Each client's in-flight reads are capped at MAX_OUTSTANDING.
// Optional macro CNDM_PROTO_DMA_RD_SCHED_STATS_EN adds the stat_issued port,
// which holds one 32-bit issued-descriptor counter per client.
module cndm_proto_dma_rd_sched #(
  parameter int PORTS           = 2,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 20,
  parameter int TAG_W           = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CL_PORTS       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS-1:0]          port_en,
  input  logic [PORTS*ADDR_W-1:0]   s_req_addr,
  input  logic [PORTS*LEN_W-1:0]    s_req_len,
  input  logic [PORTS*TAG_W-1:0]    s_req_tag,
  input  logic [PORTS-1:0]          s_req_valid,
  output logic [PORTS-1:0]          s_req_ready,
  output logic [ADDR_W-1:0]         m_req_addr,
  output logic [LEN_W-1:0]          m_req_len,
  output logic [CL_PORTS+TAG_W-1:0] m_req_tag,
  output logic                      m_req_valid,
  input  logic                      m_req_ready,
  input  logic [CL_PORTS+TAG_W-1:0] s_sts_tag,
  input  logic [3:0]                s_sts_error,
  input  logic                      s_sts_valid,
  output logic [PORTS*TAG_W-1:0]    m_sts_tag,
  output logic [PORTS*4-1:0]        m_sts_error,
  output logic [PORTS-1:0]          m_sts_valid,
  output logic [PORTS*8-1:0]        outstanding,
`ifdef CNDM_PROTO_DMA_RD_SCHED_STATS_EN
  output logic [PORTS*32-1:0]       stat_issued,
`endif
  output logic                      sts_drop
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_r, next_state_s;
  logic [CL_PORTS-1:0] rr_ptr_r, sel_r, grant_idx_s, cand_s, sts_idx_s;
  logic                grant_found_s, load_s, issue_done_s;
  logic [PORTS-1:0]    eligible_s, req_ready_s, sts_hit_s, inc_s;
  logic [7:0]          count_r [PORTS];

  assign sts_idx_s   = s_sts_tag[TAG_W +: CL_PORTS];
  assign s_req_ready = req_ready_s;

  // Per-client eligibility, issue increments, and status hits (a hit needs a live in-flight read)
  always_comb begin
    eligible_s = {PORTS{1'b0}};
    sts_hit_s  = {PORTS{1'b0}};
    inc_s      = {PORTS{1'b0}};
    for (int p = 0; p < PORTS; p++) begin
      eligible_s[p] = s_req_valid[p] && port_en[p] && (count_r[p] < 8'(MAX_OUTSTANDING));
      sts_hit_s[p]  = s_sts_valid && (sts_idx_s == CL_PORTS'(p)) && (count_r[p] != 8'd0);
      inc_s[p]      = issue_done_s && (sel_r == CL_PORTS'(p));
    end
  end

  // Round-robin search: first eligible client at or after rr_ptr_r, wrapping at PORTS
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {CL_PORTS{1'b0}};
    cand_s        = {CL_PORTS{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      cand_s = CL_PORTS'((int'(rr_ptr_r) + i) % PORTS);
      if (!grant_found_s && eligible_s[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // FSM next state: accept one client in IDLE, hold the descriptor in ISSUE until the engine takes it
  always_comb begin
    next_state_s = state_r;
    req_ready_s  = {PORTS{1'b0}};
    load_s       = 1'b0;
    issue_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          req_ready_s[grant_idx_s] = 1'b1;
          load_s                   = 1'b1;
          next_state_s             = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (m_req_ready) begin
          issue_done_s = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register; m_req_valid is high exactly while the FSM is in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      m_req_valid <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      m_req_valid <= (next_state_s == ISSUE);
    end
  end

  // Capture the granted descriptor; it stays stable for the whole ISSUE phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_addr <= {ADDR_W{1'b0}};
      m_req_len  <= {LEN_W{1'b0}};
      m_req_tag  <= {(CL_PORTS+TAG_W){1'b0}};
      sel_r      <= {CL_PORTS{1'b0}};
    end else if (load_s) begin
      m_req_addr <= s_req_addr[grant_idx_s*ADDR_W +: ADDR_W];
      m_req_len  <= s_req_len[grant_idx_s*LEN_W +: LEN_W];
      m_req_tag  <= {grant_idx_s, s_req_tag[grant_idx_s*TAG_W +: TAG_W]};
      sel_r      <= grant_idx_s;
    end
  end

  // After each completed issue, move the round-robin pointer past the served client
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= {CL_PORTS{1'b0}};
    end else if (issue_done_s) begin
      rr_ptr_r <= (sel_r == CL_PORTS'(PORTS - 1)) ? {CL_PORTS{1'b0}} : sel_r + CL_PORTS'(1);
    end
  end

  // In-flight counters: +1 on issue handshake, -1 on a routed status, unchanged when both occur
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) count_r[p] <= 8'd0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (inc_s[p] && !sts_hit_s[p]) begin
          count_r[p] <= count_r[p] + 8'd1;
        end else if (!inc_s[p] && sts_hit_s[p]) begin
          count_r[p] <= count_r[p] - 8'd1;
        end else begin
          count_r[p] <= count_r[p];
        end
      end
    end
  end

  // Route each status to its client lane one cycle later; a status with no owner sets the sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sts_valid <= {PORTS{1'b0}};
      m_sts_tag   <= {(PORTS*TAG_W){1'b0}};
      m_sts_error <= {(PORTS*4){1'b0}};
      sts_drop    <= 1'b0;
    end else begin
      m_sts_valid <= sts_hit_s;
      for (int p = 0; p < PORTS; p++) begin
        if (sts_hit_s[p]) begin
          m_sts_tag[p*TAG_W +: TAG_W] <= s_sts_tag[TAG_W-1:0];
          m_sts_error[p*4 +: 4]       <= s_sts_error;
        end
      end
      if (s_sts_valid && (sts_hit_s == {PORTS{1'b0}})) begin
        sts_drop <= 1'b1;
      end
    end
  end

  // Expose the registered counters, zero-extended to 8 bits per client
  always_comb begin
    outstanding = {(PORTS*8){1'b0}};
    for (int p = 0; p < PORTS; p++) outstanding[p*8 +: 8] = count_r[p];
  end

`ifdef CNDM_PROTO_DMA_RD_SCHED_STATS_EN
  logic [31:0] issued_r [PORTS];

  // Free-running issued-descriptor counters; they wrap naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PORTS; p++) issued_r[p] <= 32'd0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (inc_s[p]) issued_r[p] <= issued_r[p] + 32'd1;
      end
    end
  end

  // Pack the per-client counters onto the stat_issued port
  always_comb begin
    stat_issued = {(PORTS*32){1'b0}};
    for (int p = 0; p < PORTS; p++) stat_issued[p*32 +: 32] = issued_r[p];
  end
`endif

endmodule

// File: tb/tb_cndm_proto_dma_rd_sched.sv
// Self-checking bench for cndm_proto_dma_rd_sched (PORTS=2, MAX_OUTSTANDING=4).
// Table-driven arbitration and status vectors, plus hand-written multi-cycle
// sequences. A negedge monitor checks issued descriptors and routed statuses
// against scoreboard queues.
module tb_cndm_proto_dma_rd_sched;
  localparam int PORTS = 2;
  localparam int ADDR_W = 64;
  localparam int LEN_W = 20;
  localparam int TAG_W = 8;
  localparam int CL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PORTS-1:0] port_en, s_req_valid, s_req_ready, m_sts_valid;
  logic [PORTS*ADDR_W-1:0] s_req_addr;
  logic [PORTS*LEN_W-1:0] s_req_len;
  logic [PORTS*TAG_W-1:0] s_req_tag;
  logic [ADDR_W-1:0] m_req_addr;
  logic [LEN_W-1:0] m_req_len;
  logic [CL+TAG_W-1:0] m_req_tag, s_sts_tag;
  logic m_req_valid, m_req_ready, s_sts_valid, sts_drop;
  logic [3:0] s_sts_error;
  logic [PORTS*TAG_W-1:0] m_sts_tag;
  logic [PORTS*4-1:0] m_sts_error;
  logic [PORTS*8-1:0] outstanding;
`ifdef CNDM_PROTO_DMA_RD_SCHED_STATS_EN
  logic [PORTS*32-1:0] stat_issued;
`endif

  logic [ADDR_W-1:0] req_addr [PORTS];
  logic [LEN_W-1:0] req_len [PORTS];
  logic [TAG_W-1:0] req_tag [PORTS];
  assign s_req_addr = {req_addr[1], req_addr[0]};
  assign s_req_len = {req_len[1], req_len[0]};
  assign s_req_tag = {req_tag[1], req_tag[0]};

  typedef struct {logic [CL-1:0] idx; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; logic [TAG_W-1:0] tag;} req_exp_t;
  typedef struct {int lane; logic [TAG_W-1:0] tag; logic [3:0] err;} sts_exp_t;
  typedef struct {logic [1:0] valid; logic [1:0] en; logic [1:0] exp_ready;} arb_vec_t;
  typedef struct {logic [CL+TAG_W-1:0] tag; logic [3:0] err; logic [1:0] exp_valid; logic exp_drop;} sts_vec_t;

  req_exp_t req_q[$];
  sts_exp_t sts_q[$];
  int grant_log[$];
  int n_checks = 0;
  int n_fail = 0;

  cndm_proto_dma_rd_sched #(.PORTS(PORTS), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TAG_W(TAG_W), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n), .port_en(port_en),
    .s_req_addr(s_req_addr), .s_req_len(s_req_len), .s_req_tag(s_req_tag),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_req_addr(m_req_addr), .m_req_len(m_req_len), .m_req_tag(m_req_tag),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .s_sts_tag(s_sts_tag), .s_sts_error(s_sts_error), .s_sts_valid(s_sts_valid),
    .m_sts_tag(m_sts_tag), .m_sts_error(m_sts_error), .m_sts_valid(m_sts_valid),
    .outstanding(outstanding),
`ifdef CNDM_PROTO_DMA_RD_SCHED_STATS_EN
    .stat_issued(stat_issued),
`endif
    .sts_drop(sts_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic new_fields(input int p);
    req_addr[p] = {$urandom, $urandom};
    req_len[p] = LEN_W'($urandom);
    req_tag[p] = TAG_W'($urandom);
  endtask

  // Monitor: sample accepts, issue handshakes and routed statuses between clock edges
  always @(negedge clk) begin : mon
    req_exp_t re;
    sts_exp_t se;
    if (rst_n) begin
      if (s_req_ready != 2'b00) check("req_ready_onehot", 64'($countones(s_req_ready)), 64'd1);
      for (int p = 0; p < PORTS; p++) begin
        if (s_req_ready[p]) begin
          check($sformatf("ready_implies_valid%0d", p), 64'(s_req_valid[p]), 64'd1);
          req_q.push_back('{idx: CL'(p), addr: req_addr[p], len: req_len[p], tag: req_tag[p]});
        end
      end
      if (m_req_valid && m_req_ready) begin
        grant_log.push_back(int'(m_req_tag[TAG_W]));
        if (req_q.size() == 0) begin
          check("req_sb_underflow", 64'd1, 64'd0);
        end else begin
          re = req_q.pop_front();
          check("sb_req_addr", m_req_addr, re.addr);
          check("sb_req_len", 64'(m_req_len), 64'(re.len));
          check("sb_req_tag", 64'(m_req_tag), 64'({re.idx, re.tag}));
        end
      end
      if (m_sts_valid != 2'b00) begin
        check("sts_valid_onehot", 64'($countones(m_sts_valid)), 64'd1);
        if (sts_q.size() == 0) begin
          check("sts_sb_underflow", 64'd1, 64'd0);
        end else begin
          se = sts_q.pop_front();
          check("sb_sts_lane", 64'(m_sts_valid), 64'(2'b01 << se.lane));
          check("sb_sts_tag", 64'(m_sts_tag[se.lane*TAG_W +: TAG_W]), 64'(se.tag));
          check("sb_sts_err", 64'(m_sts_error[se.lane*4 +: 4]), 64'(se.err));
        end
      end
    end
  end

  task automatic run_arb(input arb_vec_t v, input string name);
    s_req_valid = v.valid;
    port_en = v.en;
    m_req_ready = 1'b1;
    #1;
    check({name, "_ready"}, 64'(s_req_ready), 64'(v.exp_ready));
    tick();
    if (v.exp_ready != 2'b00) begin
      check({name, "_mvalid"}, 64'(m_req_valid), 64'd1);
      s_req_valid = 2'b00;
      for (int p = 0; p < PORTS; p++) if (v.exp_ready[p]) new_fields(p);
      tick();
      check({name, "_mvalid_drop"}, 64'(m_req_valid), 64'd0);
    end else begin
      check({name, "_idle"}, 64'(m_req_valid), 64'd0);
    end
  endtask

  task automatic send_sts(input logic [CL+TAG_W-1:0] tag, input logic [3:0] err, input int lane);
    s_sts_tag = tag;
    s_sts_error = err;
    s_sts_valid = 1'b1;
    if (lane >= 0) sts_q.push_back('{lane: lane, tag: tag[TAG_W-1:0], err: err});
    tick();
    s_sts_valid = 1'b0;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin : main
    arb_vec_t arb_tab [10];
    sts_vec_t sts_tab [5];
    logic [ADDR_W-1:0] exp_a;
    logic [LEN_W-1:0] exp_l;
    logic [CL+TAG_W-1:0] exp_t;

    arb_tab[0] = '{2'b11, 2'b11, 2'b01};
    arb_tab[1] = '{2'b11, 2'b11, 2'b10};
    arb_tab[2] = '{2'b11, 2'b11, 2'b01};
    arb_tab[3] = '{2'b01, 2'b11, 2'b01};
    arb_tab[4] = '{2'b11, 2'b01, 2'b01};
    arb_tab[5] = '{2'b11, 2'b11, 2'b10};
    arb_tab[6] = '{2'b11, 2'b11, 2'b10};
    arb_tab[7] = '{2'b01, 2'b11, 2'b00};
    arb_tab[8] = '{2'b00, 2'b11, 2'b00};
    arb_tab[9] = '{2'b10, 2'b01, 2'b00};
    sts_tab[0] = '{{1'b0, 8'h03}, 4'h0, 2'b01, 1'b0};
    sts_tab[1] = '{{1'b1, 8'h55}, 4'h2, 2'b10, 1'b0};
    sts_tab[2] = '{{1'b1, 8'h56}, 4'h0, 2'b10, 1'b0};
    sts_tab[3] = '{{1'b1, 8'h57}, 4'hF, 2'b10, 1'b0};
    sts_tab[4] = '{{1'b1, 8'hAA}, 4'h0, 2'b00, 1'b1};

    port_en = 2'b00; s_req_valid = 2'b00; m_req_ready = 1'b0;
    s_sts_tag = '0; s_sts_error = 4'h0; s_sts_valid = 1'b0;
    req_addr[0] = 64'h0000_1000_0000_0A00; req_len[0] = 20'h00100; req_tag[0] = 8'h11;
    req_addr[1] = 64'h0000_2000_0000_0B00; req_len[1] = 20'h00200; req_tag[1] = 8'h22;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_mvalid", 64'(m_req_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_sts_drop", 64'(sts_drop), 64'd0);
    check("rst_sts_valid", 64'(m_sts_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Arbitration table: round robin, enables, cap at 4 on client 0
    for (int i = 0; i < 10; i++) run_arb(arb_tab[i], $sformatf("arb%0d", i));
    check("cap_outstanding", 64'(outstanding), 64'h0304);

    // Status table: routing, then a drop for an idle client
    for (int i = 0; i < 5; i++) begin
      s_sts_tag = sts_tab[i].tag;
      s_sts_error = sts_tab[i].err;
      s_sts_valid = 1'b1;
      if (sts_tab[i].exp_valid != 2'b00)
        sts_q.push_back('{lane: (sts_tab[i].exp_valid[1] ? 1 : 0), tag: sts_tab[i].tag[TAG_W-1:0], err: sts_tab[i].err});
      tick();
      check($sformatf("sts%0d_valid", i), 64'(m_sts_valid), 64'(sts_tab[i].exp_valid));
      check($sformatf("sts%0d_drop", i), 64'(sts_drop), 64'(sts_tab[i].exp_drop));
    end
    s_sts_valid = 1'b0;
    tick();
    check("sts_valid_clear", 64'(m_sts_valid), 64'd0);
    check("sts_outstanding", 64'(outstanding), 64'h0003);
    repeat (3) tick();
    check("sts_drop_sticky", 64'(sts_drop), 64'd1);

    // Client 0 granted again after one credit returned
    run_arb('{2'b01, 2'b11, 2'b01}, "regrant0");

    // Engine stall for 5 cycles: descriptor held, no second accept, port_en drop ignored
    s_req_valid = 2'b10; port_en = 2'b11; m_req_ready = 1'b0;
    #1;
    check("stall_ready", 64'(s_req_ready), 64'h2);
    exp_a = req_addr[1]; exp_l = req_len[1]; exp_t = {1'b1, req_tag[1]};
    tick();
    req_addr[1] = ~req_addr[1]; req_len[1] = req_len[1] + 20'd1; req_tag[1] = req_tag[1] ^ 8'hFF;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d_mvalid", c), 64'(m_req_valid), 64'd1);
      check($sformatf("stall%0d_addr", c), m_req_addr, exp_a);
      check($sformatf("stall%0d_len", c), 64'(m_req_len), 64'(exp_l));
      check($sformatf("stall%0d_tag", c), 64'(m_req_tag), 64'(exp_t));
      check($sformatf("stall%0d_no_ready", c), 64'(s_req_ready), 64'd0);
      if (c == 2) port_en = 2'b00;
      tick();
    end
    m_req_ready = 1'b1; s_req_valid = 2'b00;
    tick();
    check("stall_done_mvalid", 64'(m_req_valid), 64'd0);
    check("stall_outstanding", 64'(outstanding), 64'h0104);
    port_en = 2'b11;

    // Client 0 at cap is skipped even though rr points at it
    run_arb('{2'b10, 2'b11, 2'b10}, "cap_skip");
    check("cap_skip_outstanding", 64'(outstanding), 64'h0204);

    // Issue handshake and status on client 1 in the same cycle
    s_req_valid = 2'b10; m_req_ready = 1'b0;
    #1;
    check("same_cycle_ready", 64'(s_req_ready), 64'h2);
    tick();
    s_req_valid = 2'b00; m_req_ready = 1'b1;
    send_sts({1'b1, 8'h77}, 4'h1, 1);
    check("same_cycle_outstanding", 64'(outstanding), 64'h0204);
    check("same_cycle_sts_valid", 64'(m_sts_valid), 64'h2);

    // Drain all credits
    for (int i = 0; i < 4; i++) send_sts({1'b0, 8'(8'h30 + i)}, 4'(i), 0);
    for (int i = 0; i < 2; i++) send_sts({1'b1, 8'(8'h40 + i)}, 4'(i + 8), 1);
    tick();
    check("drain_outstanding", 64'(outstanding), 64'h0000);

    // Both clients continuously valid: grants alternate, m_req_valid every other cycle
    grant_log.delete();
    s_req_valid = 2'b11; port_en = 2'b11; m_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("alt%0d_mvalid", c), 64'(m_req_valid), (c % 2 == 0) ? 64'd1 : 64'd0);
    end
    s_req_valid = 2'b00;
    check("alt_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4)
      for (int c = 0; c < 4; c++) check($sformatf("alt_grant%0d", c), 64'(grant_log[c]), 64'(c % 2));
    tick();
    check("alt_outstanding", 64'(outstanding), 64'h0202);

    // Asynchronous reset in the middle of ISSUE
    run_arb('{2'b01, 2'b11, 2'b01}, "pre_rst");
    s_req_valid = 2'b11; m_req_ready = 1'b0;
    #1;
    check("pre_rst_ready", 64'(s_req_ready), 64'h2);
    tick();
    check("pre_rst_mvalid", 64'(m_req_valid), 64'd1);
    check("pre_rst_outstanding", 64'(outstanding), 64'h0203);
    s_req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("async_rst_mvalid", 64'(m_req_valid), 64'd0);
    check("async_rst_outstanding", 64'(outstanding), 64'd0);
    check("async_rst_sts_drop", 64'(sts_drop), 64'd0);
    req_q.delete();
    sts_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    s_req_valid = 2'b11; m_req_ready = 1'b1;
    #1;
    check("post_rst_ready", 64'(s_req_ready), 64'h1);
    tick();
    check("post_rst_tag", 64'(m_req_tag), 64'({1'b0, req_tag[0]}));
    s_req_valid = 2'b00;
    tick();
    check("post_rst_mvalid", 64'(m_req_valid), 64'd0);
    check("post_rst_outstanding", 64'(outstanding), 64'h0001);

    repeat (2) tick();
    check("req_sb_empty", 64'(req_q.size()), 64'd0);
    check("sts_sb_empty", 64'(sts_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cndm_proto_dma_rd_sched.md
Name: cndm_proto_dma_rd_sched

Overview:
Credit-limited round-robin scheduler that shares the single DMA read descriptor channel between PORTS per-port clients.
- Issues one descriptor at a time to the DMA engine.
- Stamps the client index into the upper tag bits.
- Routes read-status responses back to the originating client.
- Caps each client's in-flight reads so one port cannot starve the others.
- Sits between the per-port queue logic and the core's DMA read mux.

Parameters:
PORTS, 2, number of clients (1..16)
ADDR_W, 64, DMA address width
LEN_W, 20, transfer length width
TAG_W, 8, client-side tag width
MAX_OUTSTANDING, 4, max in-flight reads per client (1..255)
CL_PORTS, derived, max(1, $clog2(PORTS)); index field width in m_req_tag

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
port_en  in  PORTS  per-client enable; 0 blocks new grants only
s_req_addr  in  PORTS*ADDR_W  client descriptor address
s_req_len  in  PORTS*LEN_W  client descriptor length
s_req_tag  in  PORTS*TAG_W  client tag
s_req_valid  in  PORTS  client request valid
s_req_ready  out  PORTS  client request accepted
m_req_addr  out  ADDR_W  to DMA engine
m_req_len  out  LEN_W  to DMA engine
m_req_tag  out  CL_PORTS+TAG_W  {client index, client tag}
m_req_valid  out  1  descriptor valid
m_req_ready  in  1  DMA engine ready
s_sts_tag  in  CL_PORTS+TAG_W  status tag from DMA engine
s_sts_error  in  4  status error code
s_sts_valid  in  1  status valid (no backpressure)
m_sts_tag  out  PORTS*TAG_W  routed client tag
m_sts_error  out  PORTS*4  routed error code
m_sts_valid  out  PORTS  one-hot routed status pulse
outstanding  out  PORTS*8  per-client in-flight count
sts_drop  out  1  sticky: status arrived for unknown or idle client

Behaviour:
- Reset (rst_n low, asynchronous): clear all registered outputs, counters, sts_drop and state; rr pointer = 0.
- Eligibility: client p is eligible when s_req_valid[p] && port_en[p] && count[p] < MAX_OUTSTANDING.
- FSM IDLE: if any client is eligible, pick the first eligible index at or after rr_ptr (wrapping).
  - Capture addr/len/tag into output registers; m_req_tag = {p, tag}.
  - Pulse s_req_ready[p] in the same cycle.
  - Go to ISSUE; m_req_valid rises next cycle. Accept-to-valid latency is 1 cycle.
- FSM ISSUE: hold m_req_* stable while m_req_valid=1 && !m_req_ready.
  - On m_req_ready: count[p] += 1; rr_ptr = p+1 (wraps to 0 at PORTS).
  - Return to IDLE; m_req_valid drops next cycle.
  - Throughput is therefore 1 descriptor per 2 cycles minimum.
- Status routing: on s_sts_valid, idx = s_sts_tag[TAG_W +: CL_PORTS].
  - If idx < PORTS and count[idx] > 0: register tag/error into lane idx, pulse m_sts_valid[idx] next cycle (1-cycle latency), count[idx] -= 1.
  - Otherwise: drop the status, set sts_drop (cleared only by reset), counts unchanged.
- Simultaneous issue-handshake and status on the same client: count unchanged (+1 and -1 net).
- Counter saturation cannot occur: grant is blocked at MAX_OUTSTANDING. A client at its cap is skipped by arbitration; other clients proceed.
- port_en deassert while in ISSUE: the held descriptor still completes, and in-flight statuses still route.
- s_req_ready is never asserted without the matching s_req_valid; at most one bit of s_req_ready and one bit of m_sts_valid per cycle.
- outstanding[p] reflects count[p] (registered), zero-extended to 8 bits.

Optional Feature:
- Macro: CNDM_PROTO_DMA_RD_SCHED_STATS_EN.
- Defined: adds output stat_issued (PORTS*32), a per-client free-running count of issued descriptors.
  - Increments on each m_req handshake and wraps at 2^32.
  - Reset to 0.
- Undefined: port absent, no counter logic.

Test Plan:
- PORTS=2, both clients continuously valid, m_req_ready=1 -> grants alternate 0,1,0,1; m_req_tag[8]=client index; a new m_req_valid every 2 cycles.
- Client 0 issues 4 requests, no status returned, MAX_OUTSTANDING=4 -> outstanding[0]=4, client 0 blocked, client 1 still granted; return status tag {0,8'h03} -> m_sts_valid[0] pulses with m_sts_tag=8'h03, outstanding[0]=3, client 0 granted again.
- m_req_ready held low 5 cycles after m_req_valid -> addr/len/tag stable for all 5 cycles, no second s_req_ready pulse.
- Status with tag {1,8'hAA} while outstanding[1]=0 -> no m_sts_valid pulse, sts_drop=1 until reset.
- Issue handshake and status on client 1 in the same cycle, outstanding[1]=2 -> stays 2.
- rst_n pulsed low mid-ISSUE with outstanding=3 -> m_req_valid=0 immediately (asynchronous), counts=0, rr_ptr=0; the next grant goes to client 0.
